// File: rtl/fft_sample_framer.sv
// fft_sample_framer
// Collects audio samples in a FIFO and, once a whole frame of 2^L samples is
// buffered, streams that frame to the FFT input as one AXI-Stream packet.
// The frame size is captured at each frame boundary, so a packet always has
// the length the FFT was configured for when that packet started.
module fft_sample_framer #(
    parameter int SAMPLE_W = 16,
    parameter int MAX_LOG  = 10,
    parameter int MIN_LOG  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [SAMPLE_W-1:0]   sampleIn,
    input  logic                  sampleValid,
    input  logic [3:0]            frameSize,
    output logic [2*SAMPLE_W-1:0] tData,
    output logic                  tValid,
    input  logic                  tReady,
    output logic                  tLast,
    output logic                  frameActive,
    output logic                  overflow
);

    localparam int PTR_W = MAX_LOG + 1;
    localparam int CNT_W = MAX_LOG + 2;
    localparam int DEPTH = 1 << PTR_W;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [3:0]       MIN_LOG_4  = 4'(MIN_LOG);
    localparam logic [3:0]       MAX_LOG_4  = 4'(MAX_LOG);
    localparam logic [SAMPLE_W-1:0] IMAG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } framerState;

    framerState state;
    framerState nextState;

    // Sample storage and its bookkeeping
    logic [SAMPLE_W-1:0] sampleMem [DEPTH];
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [PTR_W-1:0]    rdPtrNext;
    logic [CNT_W-1:0]    count;

    // Frame geometry
    logic [3:0]          effLog;
    logic [3:0]          frameLog;
    logic [CNT_W-1:0]    frameLen;
    logic [PTR_W-1:0]    beatIdx;

    // Handshake and control strobes
    logic                fifoFull;
    logic                writeEn;
    logic                frameReady;
    logic                lastBeat;
    logic                beatXfer;
    logic                startFrame;
    logic                latchSize;

    // Clamp the requested log2 frame size into the range the framer supports.
    always_comb begin
        effLog = frameSize;
        if (frameSize < MIN_LOG_4) begin
            effLog = MIN_LOG_4;
        end else if (frameSize > MAX_LOG_4) begin
            effLog = MAX_LOG_4;
        end
    end

    // Frame length, FIFO status and read-ahead address; the full decision only
    // looks at the registered count so a same-cycle read never frees a slot.
    always_comb begin
        frameLen   = CNT_W'(1) << frameLog;
        fifoFull   = (count == FULL_COUNT);
        writeEn    = sampleValid && !fifoFull;
        frameReady = (count >= frameLen);
        lastBeat   = ({1'b0, beatIdx} == (frameLen - CNT_W'(1)));
        rdPtrNext  = rdPtr + PTR_W'(1);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: IDLE always moves on, FILL waits for a full frame,
    // SEND returns to IDLE once the last beat is accepted.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = FILL;
            FILL: begin
                if (frameReady) begin
                    nextState = SEND;
                end
            end
            SEND: begin
                if (tReady && lastBeat) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output and control decode; tValid/tLast come straight from registered
    // state so they cannot change while the consumer is stalling.
    always_comb begin
        tValid      = 1'b0;
        tLast       = 1'b0;
        frameActive = 1'b0;
        beatXfer    = 1'b0;
        startFrame  = 1'b0;
        latchSize   = 1'b0;
        case (state)
            IDLE: latchSize = 1'b1;
            FILL: startFrame = frameReady;
            SEND: begin
                tValid      = 1'b1;
                frameActive = 1'b1;
                tLast       = lastBeat;
                beatXfer    = tReady;
            end
            default: ;
        endcase
    end

    // Capture the frame size only at the frame boundary so a packet never
    // changes length mid-stream.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frameLog <= MIN_LOG_4;
        end else if (latchSize) begin
            frameLog <= effLog;
        end
    end

    // Beat counter within the current packet, cleared at every boundary.
    always_ff @(posedge CLK) begin
        if (RST) begin
            beatIdx <= '0;
        end else if (latchSize) begin
            beatIdx <= '0;
        end else if (beatXfer) begin
            beatIdx <= beatIdx + PTR_W'(1);
        end
    end

    // Sample RAM; left unreset because the pointers and count alone decide
    // which entries hold live data.
    always_ff @(posedge CLK) begin
        if (writeEn) begin
            sampleMem[wrPtr] <= sampleIn;
        end
    end

    // FIFO pointers and occupancy; a write and a read together leave the
    // count unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (writeEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (beatXfer) begin
                rdPtr <= rdPtrNext;
            end
            case ({writeEn, beatXfer})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Sticky flag recording that at least one sample was dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow <= 1'b0;
        end else if (sampleValid && fifoFull) begin
            overflow <= 1'b1;
        end
    end

    // Registered output data: the oldest sample is prefetched when the frame
    // starts, and each accepted beat loads the following sample on the same
    // edge so the stream has no bubbles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tData <= '0;
        end else if (startFrame) begin
            tData <= {IMAG_ZERO, sampleMem[rdPtr]};
        end else if (beatXfer) begin
            tData <= {IMAG_ZERO, sampleMem[rdPtrNext]};
        end
    end

endmodule

// File: tb/tb_fft_sample_framer.sv
// tb_fft_sample_framer
// Drives directed and randomized sample/backpressure traffic into
// fft_sample_framer and compares every cycle against a queue-based model of
// the framing rules.
module tb_fft_sample_framer;

    localparam int SAMPLE_W = 16;
    localparam int MAX_LOG  = 10;
    localparam int MIN_LOG  = 3;
    localparam int DEPTH    = 1 << (MAX_LOG + 1);

    logic                  CLK         = 1'b0;
    logic                  RST         = 1'b1;
    logic [SAMPLE_W-1:0]   sampleIn    = '0;
    logic                  sampleValid = 1'b0;
    logic [3:0]            frameSize   = 4'd3;
    logic                  tReady      = 1'b0;
    logic [2*SAMPLE_W-1:0] tData;
    logic                  tValid;
    logic                  tLast;
    logic                  frameActive;
    logic                  overflow;

    int compared   = 0;
    int mismatched = 0;

    fft_sample_framer #(
        .SAMPLE_W (SAMPLE_W),
        .MAX_LOG  (MAX_LOG),
        .MIN_LOG  (MIN_LOG)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .frameSize   (frameSize),
        .tData       (tData),
        .tValid      (tValid),
        .tReady      (tReady),
        .tLast       (tLast),
        .frameActive (frameActive),
        .overflow    (overflow)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference model: queue of samples held by the framer plus the framing
    // rules (size chosen in the boundary cycle, one fill cycle, whole frame
    // streamed, full decided on the occupancy before the edge).
    logic [SAMPLE_W-1:0] expQ[$];
    int                  lenLog[$];
    int                  mdlPhase    = 0;
    int                  curLen      = 8;
    int                  beatCnt     = 0;
    int                  obsBeats    = 0;
    int                  framesDone  = 0;
    logic                expOverflow = 1'b0;

    function automatic int clampLen(input logic [3:0] fs);
        int l;
        l = int'(fs);
        if (l < MIN_LOG) l = MIN_LOG;
        if (l > MAX_LOG) l = MAX_LOG;
        return 1 << l;
    endfunction

    function automatic int lenAt(input int k);
        if (k < lenLog.size()) return lenLog[k];
        return -1;
    endfunction

    // Per-cycle monitor, evaluated mid-cycle when inputs and outputs are settled.
    always @(negedge CLK) begin
        bit full;
        if (RST) begin
            expQ.delete();
            mdlPhase    = 0;
            beatCnt     = 0;
            obsBeats    = 0;
            expOverflow = 1'b0;
        end else begin
            full = (expQ.size() == DEPTH);
            checkOutput("overflow", 64'(overflow), 64'(expOverflow));
            checkOutput("frameActive", 64'(frameActive), 64'(mdlPhase == 2));
            case (mdlPhase)
                0: begin
                    checkOutput("tValidBoundary", 64'(tValid), 64'(0));
                    curLen   = clampLen(frameSize);
                    mdlPhase = 1;
                end
                1: begin
                    checkOutput("tValidFill", 64'(tValid), 64'(0));
                    if (expQ.size() >= curLen) mdlPhase = 2;
                end
                default: begin
                    checkOutput("tValidSend", 64'(tValid), 64'(1));
                    checkOutput("tData", 64'(tData), 64'({16'h0000, expQ[0]}));
                    checkOutput("tLast", 64'(tLast), 64'(beatCnt == curLen - 1));
                    if (tReady) begin
                        void'(expQ.pop_front());
                        obsBeats++;
                        if (tLast) begin
                            lenLog.push_back(obsBeats);
                            obsBeats = 0;
                        end
                        if (beatCnt == curLen - 1) begin
                            beatCnt  = 0;
                            mdlPhase = 0;
                            framesDone++;
                        end else begin
                            beatCnt++;
                        end
                    end
                end
            endcase
            if (sampleValid) begin
                if (full) expOverflow = 1'b1;
                else expQ.push_back(sampleIn);
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [SAMPLE_W-1:0] d,
                                 input logic r);
        @(posedge CLK);
        #1;
        sampleValid = v;
        sampleIn    = d;
        tReady      = r;
    endtask

    // Idle the write side until the model has seen `target` frames or the
    // budget runs out. readyMode: 0 always ready, 1 toggling, 2 random.
    task automatic waitFrames(input int target, input int budget, input int readyMode);
        int   n;
        logic r;
        n = 0;
        r = 1'b0;
        while (framesDone < target && n < budget) begin
            case (readyMode)
                1:       r = ~r;
                2:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b1;
            endcase
            applyStimulus(1'b0, '0, r);
            n++;
        end
        checkOutput("frameWait", 64'(framesDone >= target), 64'(1));
    endtask

    // Reset the DUT with a chosen frame size so the first frame uses it.
    task automatic startScenario(input logic [3:0] fs);
        frameSize = fs;
        @(posedge CLK);
        #1;
        RST         = 1'b1;
        sampleValid = 1'b0;
        tReady      = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        lenLog.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_tValid"}, 64'(tValid), 64'(0));
        checkOutput({tag, "_tLast"}, 64'(tLast), 64'(0));
        checkOutput({tag, "_tData"}, 64'(tData), 64'(0));
        checkOutput({tag, "_frameActive"}, 64'(frameActive), 64'(0));
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'(0));
    endtask

    // Hard stop in case something wedges the main sequence.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int base;
        int n;

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        checkIdleOutputs("reset");

        // Smallest frame, samples 1..8, always ready.
        base = framesDone;
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b1);
        waitFrames(base + 1, 50, 0);
        checkOutput("len8", 64'(lenAt(0)), 64'(8));

        // Two back-to-back frames: second must follow after exactly two idle cycles.
        startScenario(4'd3);
        base = framesDone;
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 16'(100 + i), 1'b1);
        waitFrames(base + 2, 60, 0);
        checkOutput("b2bLen0", 64'(lenAt(0)), 64'(8));
        checkOutput("b2bLen1", 64'(lenAt(1)), 64'(8));

        // Frame of 16 with tReady toggling.
        startScenario(4'd4);
        base = framesDone;
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 16'(200 + i), (i % 2) == 1);
        waitFrames(base + 1, 100, 1);
        checkOutput("len16toggle", 64'(lenAt(0)), 64'(16));

        // frameSize below the minimum clamps to 8 beats.
        startScenario(4'd0);
        base = framesDone;
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'($urandom), 1'b1);
        waitFrames(base + 1, 50, 0);
        checkOutput("lenClampLow", 64'(lenAt(0)), 64'(8));

        // frameSize above the maximum clamps to 1024 beats.
        startScenario(4'd15);
        base = framesDone;
        for (int i = 1; i <= 1024; i++)
            applyStimulus(1'b1, 16'($urandom), ($urandom_range(0, 3) != 0));
        waitFrames(base + 1, 4000, 2);
        checkOutput("lenClampHigh", 64'(lenAt(0)), 64'(1024));

        // Size change 4 -> 5 during SEND affects only the next packet.
        startScenario(4'd4);
        base = framesDone;
        for (int i = 1; i <= 48; i++) begin
            applyStimulus(1'b1, 16'($urandom), 1'b1);
            if (tValid) frameSize = 4'd5;
        end
        waitFrames(base + 2, 200, 0);
        checkOutput("lenBeforeChange", 64'(lenAt(0)), 64'(16));
        checkOutput("lenAfterChange", 64'(lenAt(1)), 64'(32));

        // Overflow: 2049 writes with the consumer stalled; last one dropped.
        startScenario(4'd4);
        base = framesDone;
        for (int i = 1; i <= 2049; i++) applyStimulus(1'b1, 16'(i), 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("overflowSet", 64'(overflow), 64'(1));
        waitFrames(base + 128, 4000, 0);
        checkOutput("ovfLen", 64'(lenAt(0)), 64'(16));
        checkOutput("ovfFrames", 64'(lenLog.size()), 64'(128));

        // Reset after 5 beats of a 16-beat frame.
        startScenario(4'd4);
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 16'(300 + i), 1'b1);
        n = 0;
        while (beatCnt < 5 && n < 100) begin
            applyStimulus(1'b0, '0, 1'b1);
            n++;
        end
        checkOutput("midFrameBeats", 64'(beatCnt), 64'(5));
        RST         = 1'b1;
        sampleValid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        checkIdleOutputs("midReset");
        lenLog.delete();
        base = framesDone;
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 16'(400 + i), 1'b1);
        waitFrames(base + 1, 60, 0);
        checkOutput("postResetLen", 64'(lenAt(0)), 64'(16));

        // Randomized traffic with frame size changes at arbitrary times.
        startScenario(4'($urandom_range(0, 6)));
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) frameSize = 4'($urandom_range(0, 6));
            applyStimulus(($urandom_range(0, 9) < 7), 16'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 300; c++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("randomFramesSeen", 64'(lenLog.size() > 5), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
